qea_host_sequencer: RTL and testbench
=====================================

Name: qea_host_sequencer

Overview:
Hardware sequencer that replaces host/bench-driven bring-up of the QEA core. On a run request it streams gate-context words into QEA context RAM and initialises state RAM to |0...0>. It then pulses start, times execution until complete, and streams the final state vector out with valid/ready backpressure. It sits between the host interface (DMA/AXI-stream shim) and the QEA instance.

Parameters:
PE_NUM, 4, processing elements; state row = PE_NUM amplitudes
DATA_WIDTH, 32, fixed-point word width (real or imag)
STATE_DATA_WIDTH, 64, one complex amplitude {re,im}
STATE_ADDR_WIDTH, 16, state RAM row address width
GATE_CONTEXT_DATA_WIDTH, 64, context word width
GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
MAX_QBIT_WIDTH, 6, width of qubit count
NUM_FRAC_BIT, 30, fraction bits; 1.0 = 1<<NUM_FRAC_BIT
READ_LAT, 1, state RAM read latency in cycles (>=1)
CYC_WIDTH, 32, execution cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_run  in  1  single-cycle run request
i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_run
i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  context words to load, latched on i_run
i_ctx_valid  in  1  context stream valid
i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context stream data
o_ctx_ready  out  1  context stream ready
o_rd_valid  out  1  state readback valid
o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  one state row
o_rd_last  out  1  marks final row
i_rd_ready  in  1  readback ready
o_qea_ctx_en / o_qea_ctx_wea  out  1 each  QEA context write strobes
o_qea_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context address
o_qea_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context data
o_qea_state_ena / o_qea_state_wea  out  1 each  QEA state port strobes
o_qea_state_addra  out  STATE_ADDR_WIDTH  state row address
o_qea_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state write data
o_qea_start  out  1  QEA start pulse
o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count
i_qea_complete  in  1  QEA done level
i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA state read data
o_busy  out  1  high outside IDLE
o_done  out  1  one-cycle pulse at end of drain
o_err  out  1  sticky config error, cleared by next accepted i_run
o_exec_cycles  out  CYC_WIDTH  last measured execution cycles

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters cleared. Reset mid-operation aborts immediately; no partial writes continue.
- States: IDLE, LOAD_CTX, INIT_ST, START, RUN, DRAIN, DONE.
- IDLE: i_run accepted only here; ignored when busy. Valid qbit range 2..STATE_ADDR_WIDTH+2. Out of range sets o_err and stays IDLE. Otherwise latch config, clear o_err, go LOAD_CTX, or INIT_ST if i_ins_num==0.
- LOAD_CTX: o_ctx_ready=1. Each i_ctx_valid&&o_ctx_ready cycle registers ctx_en=wea=1 with addr=k (k from 0) and data next cycle. After i_ins_num words, go INIT_ST. A valid-low cycle produces no write (en=0).
- INIT_ST: writes rows 0..2**(qbit-2)-1, one per cycle, ena=wea=1. Row 0 dina has top slot [PE_NUM*64-1 -:64] = {1<<NUM_FRAC_BIT, 0}, other slots 0. All other rows are 0. Row counter is STATE_ADDR_WIDTH+1 wide, so qbit=STATE_ADDR_WIDTH+2 terminates without wrap.
- START: o_qea_start=1 for exactly one cycle; cycle counter cleared; go RUN.
- RUN: counter +1 per cycle, saturating at all-ones. On first cycle i_qea_complete==1, copy counter to o_exec_cycles; go DRAIN.
- DRAIN: at most one read outstanding. Issue ena=1, wea=0, addr=r. Capture i_qea_state_dout READ_LAT cycles later into output register. Hold o_rd_valid until i_rd_ready, then issue r+1. o_rd_last=1 on row 2**(qbit-2)-1. Data/last stable while valid&&!ready.
- DONE: o_done pulse for 1 cycle; go IDLE.
- o_qea_qbit_num holds the latched value; it is 0 only after reset.
- o_qea_ctx_* and o_qea_state_* are 0 when not actively writing or reading.

Test Plan:
- Reset then qbit=15, ins=391 -> 391 ctx writes at addr 0..390 with data matching stream; 8192 state writes; row 0 dina = 0x40000000_00000000 in top slot, rest 0; one start pulse.
- QEA model asserts complete 100 cycles after start -> o_exec_cycles=100; 8192 rows read back in address order; o_rd_last on row 8191; o_done pulses once.
- i_rd_ready toggled randomly in DRAIN -> no row dropped or duplicated; data held stable while stalled.
- qbit=1 or qbit=19 -> o_err=1, o_busy stays 0, no QEA strobes; next valid i_run clears o_err.
- ins=0, qbit=2 -> no ctx writes; exactly 1 state row written and read back.
- Assert rst during INIT_ST and during DRAIN -> all outputs 0 same cycle; new run completes correctly.

Source files
------------

// File: rtl/qea_host_sequencer_if.sv
// qea_host_sequencer_if: host stream, readback stream and QEA RAM/control signals of the sequencer
interface qea_host_sequencer_if #(
    parameter int PE_NUM = 4,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH = 6,
    parameter int CYC_WIDTH = 32
);
    logic                                 i_run;
    logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num;
    logic                                 i_ctx_valid;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data;
    logic                                 o_ctx_ready;
    logic                                 o_rd_valid;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data;
    logic                                 o_rd_last;
    logic                                 i_rd_ready;
    logic                                 o_qea_ctx_en;
    logic                                 o_qea_ctx_wea;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data;
    logic                                 o_qea_state_ena;
    logic                                 o_qea_state_wea;
    logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina;
    logic                                 o_qea_start;
    logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num;
    logic                                 i_qea_complete;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout;
    logic                                 o_busy;
    logic                                 o_done;
    logic                                 o_err;
    logic [CYC_WIDTH-1:0]                 o_exec_cycles;

    modport master (
        input  i_run, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_data, i_rd_ready, i_qea_complete, i_qea_state_dout,
        output o_ctx_ready, o_rd_valid, o_rd_data, o_rd_last, o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr,
               o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea, o_qea_state_addra, o_qea_state_dina,
               o_qea_start, o_qea_qbit_num, o_busy, o_done, o_err, o_exec_cycles
    );
    modport slave (
        output i_run, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_data, i_rd_ready, i_qea_complete, i_qea_state_dout,
        input  o_ctx_ready, o_rd_valid, o_rd_data, o_rd_last, o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr,
               o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea, o_qea_state_addra, o_qea_state_dina,
               o_qea_start, o_qea_qbit_num, o_busy, o_done, o_err, o_exec_cycles
    );
endinterface

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: loads QEA context/state RAM, starts and times the core, then streams the state vector out
module qea_host_sequencer #(
    parameter int PE_NUM = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH = 6,
    parameter int NUM_FRAC_BIT = 30,
    parameter int READ_LAT = 1,
    parameter int CYC_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    qea_host_sequencer_if.master bus
);
    localparam int SW = PE_NUM * STATE_DATA_WIDTH;
    localparam int RW = STATE_ADDR_WIDTH + 1;
    localparam int IW = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam int LW = $clog2(READ_LAT + 1);
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << NUM_FRAC_BIT;
    localparam logic [SW-1:0] INIT_ROW = {ONE, {(SW - DATA_WIDTH){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_CTX, INIT_ST, START, RUN, DRAIN, DONE} state_t;

    state_t state;
    logic [IW-1:0] ins, k;
    logic [RW-1:0] r, last_row;
    logic [CYC_WIDTH-1:0] cyc;
    logic [LW-1:0] lat;
    logic pend;

    // row counter is one bit wider than the address so the largest qubit count ends cleanly
    assign last_row = (RW'(1) << (bus.o_qea_qbit_num - MAX_QBIT_WIDTH'(2))) - RW'(1);
    assign bus.o_busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ins <= '0;
            k <= '0;
            r <= '0;
            cyc <= '0;
            lat <= '0;
            pend <= 1'b0;
            bus.o_ctx_ready <= 1'b0;
            bus.o_rd_valid <= 1'b0;
            bus.o_rd_data <= '0;
            bus.o_rd_last <= 1'b0;
            bus.o_qea_ctx_en <= 1'b0;
            bus.o_qea_ctx_wea <= 1'b0;
            bus.o_qea_ctx_addr <= '0;
            bus.o_qea_ctx_data <= '0;
            bus.o_qea_state_ena <= 1'b0;
            bus.o_qea_state_wea <= 1'b0;
            bus.o_qea_state_addra <= '0;
            bus.o_qea_state_dina <= '0;
            bus.o_qea_start <= 1'b0;
            bus.o_qea_qbit_num <= '0;
            bus.o_done <= 1'b0;
            bus.o_err <= 1'b0;
            bus.o_exec_cycles <= '0;
        end else begin
            bus.o_qea_ctx_en <= 1'b0;
            bus.o_qea_ctx_wea <= 1'b0;
            bus.o_qea_ctx_addr <= '0;
            bus.o_qea_ctx_data <= '0;
            bus.o_qea_state_ena <= 1'b0;
            bus.o_qea_state_wea <= 1'b0;
            bus.o_qea_state_addra <= '0;
            bus.o_qea_state_dina <= '0;
            bus.o_qea_start <= 1'b0;
            bus.o_done <= 1'b0;
            case (state)
                IDLE: if (bus.i_run) begin
                    if (bus.i_qbit_num < MAX_QBIT_WIDTH'(2) || bus.i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2)) begin
                        bus.o_err <= 1'b1;
                    end else begin
                        bus.o_err <= 1'b0;
                        bus.o_qea_qbit_num <= bus.i_qbit_num;
                        ins <= bus.i_ins_num;
                        k <= '0;
                        r <= '0;
                        bus.o_ctx_ready <= bus.i_ins_num != '0;
                        state <= bus.i_ins_num == '0 ? INIT_ST : LOAD_CTX;
                    end
                end
                LOAD_CTX: if (bus.i_ctx_valid && bus.o_ctx_ready) begin
                    bus.o_qea_ctx_en <= 1'b1;
                    bus.o_qea_ctx_wea <= 1'b1;
                    bus.o_qea_ctx_addr <= k[GATE_CONTEXT_ADDR_WIDTH-1:0];
                    bus.o_qea_ctx_data <= bus.i_ctx_data;
                    k <= k + IW'(1);
                    if (k == ins - IW'(1)) begin
                        bus.o_ctx_ready <= 1'b0;
                        state <= INIT_ST;
                    end
                end
                INIT_ST: begin
                    bus.o_qea_state_ena <= 1'b1;
                    bus.o_qea_state_wea <= 1'b1;
                    bus.o_qea_state_addra <= r[STATE_ADDR_WIDTH-1:0];
                    bus.o_qea_state_dina <= r == '0 ? INIT_ROW : '0;
                    r <= r == last_row ? '0 : r + RW'(1);
                    if (r == last_row) state <= START;
                end
                START: begin
                    bus.o_qea_start <= 1'b1;
                    cyc <= '0;
                    state <= RUN;
                end
                RUN: if (bus.i_qea_complete) begin
                    bus.o_exec_cycles <= cyc;
                    bus.o_qea_state_ena <= 1'b1;
                    pend <= 1'b1;
                    lat <= '0;
                    state <= DRAIN;
                end else if (cyc != '1) begin
                    cyc <= cyc + CYC_WIDTH'(1);
                end
                // one read in flight: issue, wait READ_LAT, hold the row until the host takes it
                DRAIN: if (pend) begin
                    lat <= lat + LW'(1);
                    if (lat == LW'(READ_LAT)) begin
                        pend <= 1'b0;
                        bus.o_rd_valid <= 1'b1;
                        bus.o_rd_data <= bus.i_qea_state_dout;
                        bus.o_rd_last <= r == last_row;
                    end
                end else if (bus.o_rd_valid && bus.i_rd_ready) begin
                    bus.o_rd_valid <= 1'b0;
                    bus.o_rd_last <= 1'b0;
                    if (bus.o_rd_last) begin
                        bus.o_done <= 1'b1;
                        state <= DONE;
                    end else begin
                        r <= r + RW'(1);
                        bus.o_qea_state_ena <= 1'b1;
                        bus.o_qea_state_addra <= STATE_ADDR_WIDTH'(r + RW'(1));
                        pend <= 1'b1;
                        lat <= '0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qea_host_sequencer.sv
// tb_qea_host_sequencer: randomized directed runs against a RAM/QEA model and a row-level reference
module tb_qea_host_sequencer;
    localparam int SW = 256;
    localparam logic [SW-1:0] INIT_ROW = {32'h4000_0000, 224'h0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    qea_host_sequencer_if bus();
    qea_host_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [63:0] ctx_words[$];
    int ctx_seen, st_seen, rd_seen, starts, dones, exp_rows;
    logic [31:0] seed;
    bit rand_ready = 1'b0;
    bit stalled = 1'b0;
    logic [SW-1:0] held_data;
    logic held_last;
    logic [SW-1:0] mem [0:65535];

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // content the "executed" QEA leaves in each row on top of what the sequencer wrote
    function automatic logic [SW-1:0] pat(input logic [31:0] row);
        logic [SW-1:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = ((seed + 32'(i)) * 32'h9e3779b1) ^ (row * 32'h85ebca6b) ^ 32'(i);
        return p;
    endfunction

    function automatic logic [SW-1:0] exp_row(input int row);
        return (row == 0 ? INIT_ROW : '0) ^ pat(32'(row));
    endfunction

    always @(posedge clk) begin
        if (bus.o_qea_state_ena) begin
            if (bus.o_qea_state_wea) mem[bus.o_qea_state_addra] <= bus.o_qea_state_dina;
            else bus.i_qea_state_dout <= mem[bus.o_qea_state_addra] ^ pat(32'(bus.o_qea_state_addra));
        end
    end

    always @(negedge clk) begin
        bus.i_rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (bus.o_qea_ctx_en) begin
                chk("ctx_wea", 256'(bus.o_qea_ctx_wea), 256'(1));
                chk("ctx_addr", 256'(bus.o_qea_ctx_addr), 256'(ctx_seen));
                chk("ctx_data", 256'(bus.o_qea_ctx_data), ctx_seen < ctx_words.size() ? 256'(ctx_words[ctx_seen]) : 'x);
                ctx_seen++;
            end else begin
                chk("ctx_idle", 256'({bus.o_qea_ctx_wea, bus.o_qea_ctx_addr, bus.o_qea_ctx_data}), '0);
            end
            if (bus.o_qea_state_ena && bus.o_qea_state_wea) begin
                chk("st_addr", 256'(bus.o_qea_state_addra), 256'(st_seen));
                chk("st_dina", bus.o_qea_state_dina, st_seen == 0 ? INIT_ROW : '0);
                st_seen++;
            end else if (bus.o_qea_state_ena) begin
                chk("rd_addr", 256'(bus.o_qea_state_addra), 256'(rd_seen));
            end else begin
                chk("st_idle", 256'({bus.o_qea_state_wea, bus.o_qea_state_addra}) | bus.o_qea_state_dina, '0);
            end
            if (bus.o_qea_start) starts++;
            if (bus.o_done) dones++;
            if (stalled) begin
                chk("rd_hold_data", bus.o_rd_data, held_data);
                chk("rd_hold_last", 256'(bus.o_rd_last), 256'(held_last));
            end
            if (bus.o_rd_valid && bus.i_rd_ready) begin
                chk("rd_data", bus.o_rd_data, exp_row(rd_seen));
                chk("rd_last", 256'(bus.o_rd_last), 256'(rd_seen == exp_rows - 1));
                rd_seen++;
                stalled = 1'b0;
            end else begin
                stalled = bus.o_rd_valid;
                held_data = bus.o_rd_data;
                held_last = bus.o_rd_last;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 256'({bus.o_ctx_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_qea_ctx_en, bus.o_qea_ctx_wea,
            bus.o_qea_ctx_addr, bus.o_qea_ctx_data, bus.o_qea_state_ena, bus.o_qea_state_wea, bus.o_qea_state_addra,
            bus.o_qea_start, bus.o_qea_qbit_num, bus.o_busy, bus.o_done, bus.o_err, bus.o_exec_cycles}), '0);
        chk({tag, "_rd_data"}, bus.o_rd_data, '0);
        chk({tag, "_dina"}, bus.o_qea_state_dina, '0);
    endtask

    task automatic prep(input int q, input int ins, input bit rr);
        exp_rows = 1 << (q - 2);
        seed = $urandom;
        rand_ready = rr;
        ctx_words.delete();
        for (int i = 0; i < ins; i++) ctx_words.push_back({$urandom, $urandom});
        ctx_seen = 0;
        st_seen = 0;
        rd_seen = 0;
        starts = 0;
        dones = 0;
    endtask

    task automatic run_cmd(input int q, input int ins);
        @(negedge clk);
        bus.i_run = 1'b1;
        bus.i_qbit_num = 6'(q);
        bus.i_ins_num = 17'(ins);
        @(negedge clk);
        bus.i_run = 1'b0;
    endtask

    task automatic abort_now(input string tag);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        bus.i_qea_complete = 1'b0;
        bus.i_ctx_valid = 1'b0;
        bus.i_run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic full_run(input int q, input int ins, input int lat_n, input bit rr, input bit abort_drain);
        int t;
        int i;
        prep(q, ins, rr);
        run_cmd(q, ins);
        chk("busy_after_run", 256'(bus.o_busy), 256'(1));
        chk("err_cleared", 256'(bus.o_err), 256'(0));
        chk("qbit_latched", 256'(bus.o_qea_qbit_num), 256'(q));
        i = 0;
        for (t = 0; i < ins && t < ins * 20 + 20; t++) begin
            bus.i_ctx_valid = $urandom_range(0, 3) != 0;
            bus.i_ctx_data = bus.i_ctx_valid ? ctx_words[i] : {$urandom, $urandom};
            if (bus.i_ctx_valid && bus.o_ctx_ready) i++;
            @(negedge clk);
        end
        bus.i_ctx_valid = 1'b0;
        for (t = 0; !bus.o_qea_start && t < exp_rows + 50; t++) @(negedge clk);
        chk("start_seen", 256'(bus.o_qea_start), 256'(1));
        repeat (lat_n) @(posedge clk);
        #1 bus.i_qea_complete = 1'b1;
        if (abort_drain) begin
            for (t = 0; rd_seen < 3 && t < 200; t++) @(negedge clk);
            chk("drain_reached", 256'(rd_seen >= 3), 256'(1));
            abort_now("rst_drain");
            return;
        end
        for (t = 0; !bus.o_done && t < exp_rows * 30 + 200; t++) @(negedge clk);
        chk("done_seen", 256'(bus.o_done), 256'(1));
        bus.i_qea_complete = 1'b0;
        @(negedge clk);
        chk("ctx_count", 256'(ctx_seen), 256'(ins));
        chk("st_count", 256'(st_seen), 256'(exp_rows));
        chk("rd_count", 256'(rd_seen), 256'(exp_rows));
        chk("start_count", 256'(starts), 256'(1));
        chk("done_count", 256'(dones), 256'(1));
        chk("exec_cycles", 256'(bus.o_exec_cycles), 256'(lat_n));
        chk("idle_after", 256'(bus.o_busy), 256'(0));
    endtask

    initial begin
        bus.i_run = 1'b0;
        bus.i_qbit_num = '0;
        bus.i_ins_num = '0;
        bus.i_ctx_valid = 1'b0;
        bus.i_ctx_data = '0;
        bus.i_qea_complete = 1'b0;
        prep(2, 0, 1'b0);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // out-of-range qubit counts: error flag only, no activity
        run_cmd(1, 5);
        chk("err_low", 256'(bus.o_err), 256'(1));
        chk("busy_low", 256'(bus.o_busy), 256'(0));
        run_cmd(19, 5);
        repeat (4) @(negedge clk);
        chk("err_high", 256'(bus.o_err), 256'(1));
        chk("busy_high", 256'(bus.o_busy), 256'(0));
        chk("no_strobes", 256'(ctx_seen + st_seen + starts), 256'(0));

        full_run(15, 391, 100, 1'b1, 1'b0);
        full_run(2, 0, $urandom_range(1, 20), 1'b1, 1'b0);

        prep(8, 0, 1'b0);
        run_cmd(8, 0);
        repeat (10) @(negedge clk);
        chk("init_active", 256'(bus.o_qea_state_wea), 256'(1));
        abort_now("rst_init");
        full_run(5, 7, $urandom_range(1, 20), 1'b1, 1'b0);

        full_run(6, 3, $urandom_range(1, 20), 1'b1, 1'b1);
        full_run(4, 2, $urandom_range(1, 20), 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
